// File: rtl/load_store_unit.sv
// Load/store unit: checks each decoded memory access, runs one req/ack data-bus transaction,
// steers store byte lanes, extends load data, and holds the pipeline until the access ends.
//
// state | meaning
// IDLE  | waiting for a request; a bad access faults here without touching the bus
// BUS   | dmem_req high, waiting for dmem_ack or the timeout
// RESP  | one-cycle completion: load_valid or timeout fault; request inputs ignored
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_addr,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic [4:0]  load_rd,
  output logic        lsu_fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TC = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] cnt_inc;
  logic          fault_q, fault_nxt;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [4:0]    rd_q;

  logic          req_any;
  logic          misaligned;
  logic          illegal;
  logic          bad_access;
  logic          accept;
  logic          capture_load;
  logic [31:0]   st_wdata;
  logic [3:0]    st_wstrb;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ld_ext;

  assign req_any = mem_read_en | mem_write_en;
  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      2'b11:   illegal    = 1'b1;
      default: misaligned = 1'b0;
    endcase
    // Stores have no unsigned variants; a write request wins over a read.
    if (mem_write_en && funct3[2])
      illegal = 1'b1;
    if (!mem_write_en && (funct3 == 3'b110))
      illegal = 1'b1;
  end

  assign bad_access = misaligned | illegal;

  always_comb begin
    st_wdata = store_data;
    st_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{store_data[7:0]}};
        st_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{store_data[15:0]}};
        st_wstrb = 4'b0011 << {addr[1], 1'b0};
      end
      default: begin
        st_wdata = store_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    case (off_q)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_ext = {24'd0, byte_sel};
      3'b101:  ld_ext = {16'd0, half_sel};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    fault_nxt    = fault_q;
    accept       = 1'b0;
    capture_load = 1'b0;
    stall        = 1'b0;
    lsu_fault    = 1'b0;
    load_valid   = 1'b0;
    dmem_req     = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          if (bad_access) begin
            lsu_fault = 1'b1;
          end else begin
            accept    = 1'b1;
            stall     = 1'b1;
            cnt_nxt   = '0;
            fault_nxt = 1'b0;
            state_nxt = BUS;
          end
        end
      end
      BUS: begin
        dmem_req = 1'b1;
        stall    = 1'b1;
        cnt_nxt  = cnt_inc;
        if (dmem_ack) begin
          capture_load = ~dmem_we;
          state_nxt    = RESP;
        end else if (cnt_inc == TC) begin
          fault_nxt = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        lsu_fault  = fault_q;
        load_valid = ~fault_q & ~dmem_we;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      fault_q    <= 1'b0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      rd_q       <= 5'd0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_wstrb <= 4'd0;
      load_data  <= 32'd0;
      load_rd    <= 5'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      fault_q <= fault_nxt;
      if (accept) begin
        f3_q       <= funct3;
        off_q      <= addr[1:0];
        rd_q       <= rd_addr;
        dmem_we    <= mem_write_en;
        dmem_addr  <= {addr[31:2], 2'b00};
        dmem_wdata <= mem_write_en ? st_wdata : 32'd0;
        dmem_wstrb <= mem_write_en ? st_wstrb : 4'b0000;
      end
      if (capture_load) begin
        load_data <= ld_ext;
        load_rd   <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT=4: stores, loads, faults, timeout and reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_read_en = 1'b0;
  logic        mem_write_en = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [4:0]  rd_addr = 5'd0;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic [4:0]  load_rd;
  logic        lsu_fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .funct3(funct3),
    .addr(addr), .store_data(store_data), .rd_addr(rd_addr),
    .stall(stall), .load_valid(load_valid), .load_data(load_data), .load_rd(load_rd),
    .lsu_fault(lsu_fault), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int          ob_stall, ob_req, ob_req_first, ob_lv_cyc, ob_fault_cyc, ob_end;
  logic [31:0] ob_addr, ob_wdata, ob_ld;
  logic [3:0]  ob_wstrb;
  logic        ob_we;
  logic [4:0]  ob_rd;

  // Drives one instruction (held while stalled), answers the bus with ack in cycle ack_cyc
  // (-1 = never), and records what the DUT did each cycle. ob_end = -1 means it never finished.
  task automatic run_access(input logic wr, input logic rd_en, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rdi,
                            input int ack_cyc, input logic [31:0] rdata);
    ob_stall = 0; ob_req = 0; ob_req_first = -1; ob_lv_cyc = -1; ob_fault_cyc = -1; ob_end = -1;
    ob_addr = 32'hx; ob_wdata = 32'hx; ob_wstrb = 4'hx; ob_we = 1'bx; ob_ld = 32'hx; ob_rd = 5'hx;
    for (int c = 0; c < 20 && ob_end < 0; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        mem_write_en = wr; mem_read_en = rd_en; funct3 = f3;
        addr = a; store_data = sd; rd_addr = rdi;
      end
      dmem_ack   = (c == ack_cyc);
      dmem_rdata = (c == ack_cyc) ? rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      if (stall) ob_stall++;
      if (dmem_req) begin
        if (ob_req_first < 0) begin
          ob_req_first = c; ob_addr = dmem_addr; ob_wdata = dmem_wdata;
          ob_wstrb = dmem_wstrb; ob_we = dmem_we;
        end
        ob_req++;
      end
      if (load_valid) begin ob_lv_cyc = c; ob_ld = load_data; ob_rd = load_rd; end
      if (lsu_fault) ob_fault_cyc = c;
      if (!stall) ob_end = c;
    end
    @(posedge clk); #1;
    mem_write_en = 1'b0; mem_read_en = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({dmem_req, stall, load_valid, lsu_fault, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata, load_data, load_rd} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got req=%b stall=%b lv=%b fault=%b addr=%h ld=%h want all zero",
                        dmem_req, stall, load_valid, lsu_fault, dmem_addr, load_data);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_store_byte;
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'hAABB_CCDD, 5'd0, 1, 32'd0);
    n_cmp++;
    if (ob_end !== 2 || ob_stall !== 2) begin
      n_err++; $display("FAIL sb_timing: got end=%0d stall_cycles=%0d want 2/2", ob_end, ob_stall);
    end
    n_cmp++;
    if (ob_req_first !== 1 || ob_req !== 1) begin
      n_err++; $display("FAIL sb_req: got first=%0d count=%0d want 1/1", ob_req_first, ob_req);
    end
    n_cmp++;
    if ({ob_we, ob_wstrb, ob_addr, ob_wdata} !== {1'b1, 4'b1000, 32'h0000_0100, 32'hDDDD_DDDD}) begin
      n_err++; $display("FAIL sb_bus: got we=%b strb=%b addr=%h wdata=%h want 1/1000/00000100/dddddddd",
                        ob_we, ob_wstrb, ob_addr, ob_wdata);
    end
    n_cmp++;
    if (ob_lv_cyc !== -1 || ob_fault_cyc !== -1) begin
      n_err++; $display("FAIL sb_pulse: got lv_cyc=%0d fault_cyc=%0d want none", ob_lv_cyc, ob_fault_cyc);
    end
  endtask

  task automatic test_store_half_dual;
    run_access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'hAABB_CCDD, 5'd0, 1, 32'd0);
    n_cmp++;
    if ({ob_we, ob_wstrb, ob_wdata} !== {1'b1, 4'b1100, 32'hCCDD_CCDD}) begin
      n_err++; $display("FAIL sh_bus: got we=%b strb=%b wdata=%h want 1/1100/ccddccdd", ob_we, ob_wstrb, ob_wdata);
    end
    // read and write together behave as a store
    run_access(1'b1, 1'b1, 3'b010, 32'h0000_0200, 32'h1122_3344, 5'd3, 2, 32'h5555_5555);
    n_cmp++;
    if ({ob_we, ob_wstrb, ob_addr, ob_wdata} !== {1'b1, 4'b1111, 32'h0000_0200, 32'h1122_3344} || ob_lv_cyc !== -1) begin
      n_err++; $display("FAIL dual_req_store: got we=%b strb=%b addr=%h wdata=%h lv_cyc=%0d want store, no load_valid",
                        ob_we, ob_wstrb, ob_addr, ob_wdata, ob_lv_cyc);
    end
  endtask

  task automatic test_load_byte;
    run_access(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'd0, 5'd9, 3, 32'h1234_F678);
    n_cmp++;
    if (ob_stall !== 4 || ob_lv_cyc !== 4 || ob_req !== 3) begin
      n_err++; $display("FAIL lb_timing: got stall=%0d lv_cyc=%0d req=%0d want 4/4/3", ob_stall, ob_lv_cyc, ob_req);
    end
    n_cmp++;
    if ({ob_ld, ob_rd, ob_we, ob_wstrb, ob_addr} !== {32'hFFFF_FFF6, 5'd9, 1'b0, 4'b0000, 32'h0000_0100}) begin
      n_err++; $display("FAIL lb_data: got data=%h rd=%0d we=%b strb=%b addr=%h want ffffff f6/9/0/0000/100",
                        ob_ld, ob_rd, ob_we, ob_wstrb, ob_addr);
    end
    run_access(1'b0, 1'b1, 3'b100, 32'h0000_0101, 32'd0, 5'd10, 3, 32'h1234_F678);
    n_cmp++;
    if (ob_ld !== 32'h0000_00F6 || ob_rd !== 5'd10 || ob_lv_cyc !== 4) begin
      n_err++; $display("FAIL lbu_data: got data=%h rd=%0d lv_cyc=%0d want 000000f6/10/4", ob_ld, ob_rd, ob_lv_cyc);
    end
  endtask

  task automatic test_load_half_word;
    run_access(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'd0, 5'd11, 1, 32'h8001_ABCD);
    n_cmp++;
    if (ob_ld !== 32'hFFFF_8001 || ob_rd !== 5'd11 || ob_lv_cyc !== 2) begin
      n_err++; $display("FAIL lh_data: got data=%h rd=%0d lv_cyc=%0d want ffff8001/11/2", ob_ld, ob_rd, ob_lv_cyc);
    end
    run_access(1'b0, 1'b1, 3'b101, 32'h0000_0102, 32'd0, 5'd12, 1, 32'h8001_ABCD);
    n_cmp++;
    if (ob_ld !== 32'h0000_8001 || ob_rd !== 5'd12) begin
      n_err++; $display("FAIL lhu_data: got data=%h rd=%0d want 00008001/12", ob_ld, ob_rd);
    end
    run_access(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'd0, 5'd31, 1, 32'h8001_ABCD);
    n_cmp++;
    if (ob_ld !== 32'h8001_ABCD || ob_rd !== 5'd31) begin
      n_err++; $display("FAIL lw_data: got data=%h rd=%0d want 8001abcd/31", ob_ld, ob_rd);
    end
    // result holds after RESP; stray ack in IDLE is ignored
    dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    n_cmp++;
    if ({load_valid, stall, dmem_req, load_data, load_rd} !== {3'b000, 32'h8001_ABCD, 5'd31}) begin
      n_err++; $display("FAIL idle_hold: got lv=%b stall=%b req=%b data=%h rd=%0d want 0/0/0/8001abcd/31",
                        load_valid, stall, dmem_req, load_data, load_rd);
    end
    @(posedge clk); #1; dmem_ack = 1'b0;
  endtask

  task automatic test_faults;
    run_access(1'b0, 1'b1, 3'b001, 32'h0000_0103, 32'd0, 5'd4, 1, 32'd0);
    n_cmp++;
    if (ob_fault_cyc !== 0 || ob_stall !== 0 || ob_req !== 0 || ob_lv_cyc !== -1) begin
      n_err++; $display("FAIL lh_misaligned: got fault_cyc=%0d stall=%0d req=%0d lv=%0d want 0/0/0/-1",
                        ob_fault_cyc, ob_stall, ob_req, ob_lv_cyc);
    end
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h1234_5678, 5'd0, 1, 32'd0);
    n_cmp++;
    if (ob_fault_cyc !== 0 || ob_stall !== 0 || ob_req !== 0) begin
      n_err++; $display("FAIL sw_misaligned: got fault_cyc=%0d stall=%0d req=%0d want 0/0/0", ob_fault_cyc, ob_stall, ob_req);
    end
    run_access(1'b0, 1'b1, 3'b011, 32'h0000_0100, 32'd0, 5'd4, 1, 32'd0);
    n_cmp++;
    if (ob_fault_cyc !== 0 || ob_req !== 0) begin
      n_err++; $display("FAIL load_illegal_f3: got fault_cyc=%0d req=%0d want 0/0", ob_fault_cyc, ob_req);
    end
    run_access(1'b1, 1'b0, 3'b100, 32'h0000_0100, 32'd0, 5'd0, 1, 32'd0);
    n_cmp++;
    if (ob_fault_cyc !== 0 || ob_req !== 0) begin
      n_err++; $display("FAIL store_illegal_f3: got fault_cyc=%0d req=%0d want 0/0", ob_fault_cyc, ob_req);
    end
  endtask

  task automatic test_timeout;
    run_access(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'd0, 5'd6, -1, 32'd0);
    n_cmp++;
    if (ob_req !== 4 || ob_fault_cyc !== 5 || ob_lv_cyc !== -1 || ob_stall !== 5) begin
      n_err++; $display("FAIL timeout: got req=%0d fault_cyc=%0d lv=%0d stall=%0d want 4/5/-1/5",
                        ob_req, ob_fault_cyc, ob_lv_cyc, ob_stall);
    end
    run_access(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'd0, 5'd6, 2, 32'hCAFE_F00D);
    n_cmp++;
    if (ob_ld !== 32'hCAFE_F00D || ob_lv_cyc !== 3 || ob_fault_cyc !== -1) begin
      n_err++; $display("FAIL after_timeout_lw: got data=%h lv_cyc=%0d fault_cyc=%0d want cafef00d/3/-1",
                        ob_ld, ob_lv_cyc, ob_fault_cyc);
    end
  endtask

  task automatic test_reset_mid_bus;
    @(posedge clk); #1;
    mem_read_en = 1'b1; funct3 = 3'b010; addr = 32'h0000_0100; rd_addr = 5'd7; dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (dmem_req !== 1'b1 || stall !== 1'b1) begin
      n_err++; $display("FAIL mid_bus_req: got req=%b stall=%b want 1/1", dmem_req, stall);
    end
    #2; reset_n = 1'b0; mem_read_en = 1'b0;
    #1;
    n_cmp++;
    if ({dmem_req, stall, load_valid, lsu_fault, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata, load_data, load_rd} !== '0) begin
      n_err++; $display("FAIL mid_bus_reset: got req=%b stall=%b lv=%b fault=%b addr=%h ld=%h rd=%0d want all zero",
                        dmem_req, stall, load_valid, lsu_fault, dmem_addr, load_data, load_rd);
    end
    @(posedge clk); #1; reset_n = 1'b1;
    run_access(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'd0, 5'd8, 2, 32'h1357_9BDF);
    n_cmp++;
    if (ob_ld !== 32'h1357_9BDF || ob_rd !== 5'd8 || ob_lv_cyc !== 3) begin
      n_err++; $display("FAIL post_reset_lw: got data=%h rd=%0d lv_cyc=%0d want 13579bdf/8/3", ob_ld, ob_rd, ob_lv_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_store_half_dual();
    test_load_byte();
    test_load_half_word();
    test_faults();
    test_timeout();
    test_reset_mid_bus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
